// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA/VESA raster timing generator. A prescaler divides the
// system clock into pixel ticks. On every tick the horizontal and vertical
// counters advance through active, front porch, sync and back porch. Every
// output is registered and decoded from the next-state counter values, so
// x, y, hsync, vsync and de always describe the same pixel with no skew.
//
// Optional feature (define VGA_TIMING_FRAME_CNT_EN):
//   adds a 16-bit frame counter (frame_cnt) and its LSB (odd_frame).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           run enable; when low, prescaler and counters hold
//   pix_tick     one-clk pulse in the clk where a new pixel is presented
//   hsync        horizontal sync, active level set by H_POL
//   vsync        vertical sync, active level set by V_POL
//   de           data enable, high inside the active window
//   x            horizontal position, 0..H_TOTAL-1
//   y            vertical position, 0..V_TOTAL-1
//   line_start   one-clk pulse when x wraps to 0
//   frame_start  one-clk pulse when (x,y) wraps to (0,0)
//   frame_cnt    (optional) frames started since reset, wraps at 65535
//   odd_frame    (optional) frame_cnt[0]
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CLK_DIV  = 2,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt,
    output logic          odd_frame
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW1     = XW + 1;
    localparam int YW1     = YW + 1;

    localparam longint H_CAP = longint'(1) << XW;
    localparam longint V_CAP = longint'(1) << YW;

    // Region boundaries are held one bit wider than the counters so that an
    // exclusive end equal to 2^XW (or 2^YW) still fits without wrapping.
    localparam logic [XW-1:0] X_LAST    = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_TOTAL - 1);
    localparam logic [XW:0]   H_ACT_END = XW1'(H_ACTIVE);
    localparam logic [XW:0]   HS_FIRST  = XW1'(H_ACTIVE + H_FP);
    localparam logic [XW:0]   HS_END    = XW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0]   V_ACT_END = YW1'(V_ACTIVE);
    localparam logic [YW:0]   VS_FIRST  = YW1'(V_ACTIVE + V_FP);
    localparam logic [YW:0]   VS_END    = YW1'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [3:0] PRE_LAST = 4'(CLK_DIV - 1);
    localparam logic       HS_ON    = (H_POL != 0);
    localparam logic       VS_ON    = (V_POL != 0);

    // Reject parameter sets the counters cannot represent.
    if (longint'(H_TOTAL) > H_CAP) begin : g_bad_xw
        $error("vga_timing_gen: H_TOTAL does not fit in XW bits");
    end
    if (longint'(V_TOTAL) > V_CAP) begin : g_bad_yw
        $error("vga_timing_gen: V_TOTAL does not fit in YW bits");
    end
    if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be within 1..16");
    end

    logic [3:0]    pre_cnt;
    logic          tick;
    logic          x_wrap;
    logic          y_wrap;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    logic          hs_act_next;
    logic          vs_act_next;
    logic          de_next;

    // Next-position computation and region decode. Everything here looks at
    // the position the raster is about to move to, so the registered outputs
    // land on the tick edge already describing that new pixel.
    always_comb begin
        tick        = en && (pre_cnt == PRE_LAST);
        x_wrap      = (x == X_LAST);
        y_wrap      = (y == Y_LAST);
        x_next      = x_wrap ? '0 : x + 1'b1;
        y_next      = y;
        if (x_wrap) begin
            y_next = y_wrap ? '0 : y + 1'b1;
        end
        hs_act_next = ({1'b0, x_next} >= HS_FIRST) && ({1'b0, x_next} < HS_END);
        vs_act_next = ({1'b0, y_next} >= VS_FIRST) && ({1'b0, y_next} < VS_END);
        de_next     = ({1'b0, x_next} < H_ACT_END) && ({1'b0, y_next} < V_ACT_END);
    end

    // Prescaler. It only moves while enabled, so a pause keeps its phase and
    // the next tick arrives exactly as many enabled clocks later as it would
    // have without the pause. With CLK_DIV=1 it stays at 0 and every enabled
    // clock is a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? 4'd0 : pre_cnt + 4'd1;
        end
    end

    // Raster position and decoded outputs. All are loaded together on the
    // tick so they never disagree about which pixel is current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            y     <= '0;
            hsync <= ~HS_ON;
            vsync <= ~VS_ON;
            de    <= 1'b1;
        end else if (tick) begin
            x     <= x_next;
            y     <= y_next;
            hsync <= hs_act_next ? HS_ON : ~HS_ON;
            vsync <= vs_act_next ? VS_ON : ~VS_ON;
            de    <= de_next;
        end
    end

    // Strobes are high only in the clock where a new position is presented;
    // because they follow tick, a disabled clock forces them low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_tick    <= tick;
            line_start  <= tick && x_wrap;
            frame_start <= tick && x_wrap && y_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Frame counter moves on the same edge that raises frame_start, so it
    // already holds the new frame number while frame_start is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (tick && x_wrap && y_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign odd_frame = frame_cnt[0];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Self-checking bench for vga_timing_gen using a tiny 14x7 raster.
// Three instances share clk/en/rst_n:
//   d1: CLK_DIV=1, active-low syncs
//   d2: CLK_DIV=2, active-low syncs
//   d3: CLK_DIV=3, active-high syncs
// The reference model counts enabled clocks since reset and derives the
// expected position and signals arithmetically from that count.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int XW = 4;
    localparam int YW = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic chk_on;

    logic          d1_pt, d1_hs, d1_vs, d1_de, d1_ls, d1_fs;
    logic [XW-1:0] d1_x;
    logic [YW-1:0] d1_y;
    logic          d2_pt, d2_hs, d2_vs, d2_de, d2_ls, d2_fs;
    logic [XW-1:0] d2_x;
    logic [YW-1:0] d2_y;
    logic          d3_pt, d3_hs, d3_vs, d3_de, d3_ls, d3_fs;
    logic [XW-1:0] d3_x;
    logic [YW-1:0] d3_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] d1_fc, d2_fc, d3_fc;
    logic        d1_odd, d2_odd, d3_odd;
`endif

    int vec_cnt  = 0;
    int miscmp   = 0;

    // Model state: enabled clocks since reset, and whether the last edge was enabled.
    int ec;
    bit le;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(0), .V_POL(0), .CLK_DIV(1), .XW(XW), .YW(YW)
    ) d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(d1_pt),
        .hsync(d1_hs), .vsync(d1_vs), .de(d1_de), .x(d1_x), .y(d1_y),
        .line_start(d1_ls), .frame_start(d1_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(d1_fc), .odd_frame(d1_odd)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(0), .V_POL(0), .CLK_DIV(2), .XW(XW), .YW(YW)
    ) d2 (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(d2_pt),
        .hsync(d2_hs), .vsync(d2_vs), .de(d2_de), .x(d2_x), .y(d2_y),
        .line_start(d2_ls), .frame_start(d2_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(d2_fc), .odd_frame(d2_odd)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1), .V_POL(1), .CLK_DIV(3), .XW(XW), .YW(YW)
    ) d3 (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(d3_pt),
        .hsync(d3_hs), .vsync(d3_vs), .de(d3_de), .x(d3_x), .y(d3_y),
        .line_start(d3_ls), .frame_start(d3_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(d3_fc), .odd_frame(d3_odd)
`endif
    );

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] fc;
        logic        hs;
        logic        vs;
        logic        de;
        logic        pt;
        logic        ls;
        logic        fs;
    } exp_t;

    typedef struct {
        int n;
        int ex;
        int ey;
        bit ehs;
        bit evs;
        bit ede;
        bit efs;
    } vec_t;

    // Count enabled clocks since reset; this single number determines the
    // expected state of every instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ec <= 0;
            le <= 1'b0;
        end else begin
            le <= en;
            if (en) ec <= ec + 1;
        end
    end

    // Expected outputs after `cnt` enabled clocks with a divide of d.
    function automatic exp_t model(input int cnt, input bit last_en, input int d,
                                   input bit hpol, input bit vpol);
        exp_t e;
        int   t;
        t    = cnt / d;
        e.x  = t % HT;
        e.y  = (t / HT) % VT;
        e.fc = (t / (HT * VT)) % 65536;
        e.pt = last_en && (cnt % d == 0);
        e.ls = e.pt && (e.x == 0);
        e.fs = e.ls && (e.y == 0);
        e.hs = (e.x >= HA + HF && e.x < HA + HF + HS) ? hpol : !hpol;
        e.vs = (e.y >= VA + VF && e.y < VA + VF + VS) ? vpol : !vpol;
        e.de = (e.x < HA) && (e.y < VA);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            miscmp++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic checkInst(input string tag, input int d, input bit hp, input bit vp,
                             input logic [31:0] ax, input logic [31:0] ay,
                             input logic ahs, input logic avs, input logic ade,
                             input logic apt, input logic als, input logic afs);
        exp_t e;
        e = model(ec, le, d, hp, vp);
        checkOutput({tag, ".x"}, ax, e.x);
        checkOutput({tag, ".y"}, ay, e.y);
        checkOutput({tag, ".hsync"}, 32'(ahs), 32'(e.hs));
        checkOutput({tag, ".vsync"}, 32'(avs), 32'(e.vs));
        checkOutput({tag, ".de"}, 32'(ade), 32'(e.de));
        checkOutput({tag, ".pix_tick"}, 32'(apt), 32'(e.pt));
        checkOutput({tag, ".line_start"}, 32'(als), 32'(e.ls));
        checkOutput({tag, ".frame_start"}, 32'(afs), 32'(e.fs));
    endtask

    // Continuous model comparison on the falling edge, away from the
    // active edge where outputs change.
    always @(negedge clk) begin
        if (chk_on) begin
            checkInst("d1", 1, 1'b0, 1'b0, 32'(d1_x), 32'(d1_y), d1_hs, d1_vs, d1_de, d1_pt, d1_ls, d1_fs);
            checkInst("d2", 2, 1'b0, 1'b0, 32'(d2_x), 32'(d2_y), d2_hs, d2_vs, d2_de, d2_pt, d2_ls, d2_fs);
            checkInst("d3", 3, 1'b1, 1'b1, 32'(d3_x), 32'(d3_y), d3_hs, d3_vs, d3_de, d3_pt, d3_ls, d3_fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
            checkOutput("d1.frame_cnt", 32'(d1_fc), model(ec, le, 1, 1'b0, 1'b0).fc);
            checkOutput("d2.frame_cnt", 32'(d2_fc), model(ec, le, 2, 1'b0, 1'b0).fc);
            checkOutput("d3.frame_cnt", 32'(d3_fc), model(ec, le, 3, 1'b1, 1'b1).fc);
            checkOutput("d1.odd_frame", 32'(d1_odd), 32'(model(ec, le, 1, 1'b0, 1'b0).fc % 2));
            checkOutput("d3.odd_frame", 32'(d3_odd), 32'(model(ec, le, 3, 1'b1, 1'b1).fc % 2));
`endif
        end
    end

    // Drive en for n clocks, returning on a falling edge.
    task automatic applyStimulus(input int n, input logic e);
        en = e;
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[16];

    initial begin
        int cur;

        // Expected d1 state after n enabled clocks from reset release.
        tbl[0]  = '{0,  0,  0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{7,  7,  0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{8,  8,  0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{10, 10, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{11, 11, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{12, 12, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{13, 13, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{14, 0,  1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{49, 7,  3, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{50, 8,  3, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{56, 0,  4, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{70, 0,  5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{80, 10, 5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{84, 0,  6, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{97, 13, 6, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{98, 0,  0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n  = 1'b0;
        en     = 1'b0;
        chk_on = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst.x", 32'(d1_x), 0);
        checkOutput("rst.y", 32'(d1_y), 0);
        checkOutput("rst.hsync_lowpol", 32'(d1_hs), 1);
        checkOutput("rst.vsync_lowpol", 32'(d1_vs), 1);
        checkOutput("rst.hsync_highpol", 32'(d3_hs), 0);
        checkOutput("rst.vsync_highpol", 32'(d3_vs), 0);
        checkOutput("rst.de", 32'(d1_de), 1);
        checkOutput("rst.pix_tick", 32'(d1_pt), 0);
        checkOutput("rst.frame_start", 32'(d1_fs), 0);

        rst_n  = 1'b1;
        en     = 1'b1;
        chk_on = 1'b1;

        $display("[TB] table-driven raster walk");
        cur = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].n - cur, 1'b1);
            cur = tbl[i].n;
            checkOutput($sformatf("tbl%0d.x", i), 32'(d1_x), tbl[i].ex);
            checkOutput($sformatf("tbl%0d.y", i), 32'(d1_y), tbl[i].ey);
            checkOutput($sformatf("tbl%0d.hsync", i), 32'(d1_hs), 32'(tbl[i].ehs));
            checkOutput($sformatf("tbl%0d.vsync", i), 32'(d1_vs), 32'(tbl[i].evs));
            checkOutput($sformatf("tbl%0d.de", i), 32'(d1_de), 32'(tbl[i].ede));
            checkOutput($sformatf("tbl%0d.frame_start", i), 32'(d1_fs), 32'(tbl[i].efs));
        end

        $display("[TB] async reset mid-frame");
        applyStimulus(81, 1'b1);
        checkOutput("pre_rst.x", 32'(d1_x), 11);
        checkOutput("pre_rst.y", 32'(d1_y), 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst.x", 32'(d1_x), 0);
        checkOutput("arst.y", 32'(d1_y), 0);
        checkOutput("arst.hsync", 32'(d1_hs), 1);
        checkOutput("arst.vsync", 32'(d1_vs), 1);
        checkOutput("arst.de", 32'(d1_de), 1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 1'b1);
        checkOutput("post_rst.x", 32'(d1_x), 1);
        checkOutput("post_rst.pix_tick", 32'(d1_pt), 1);
        applyStimulus(2, 1'b1);
        checkOutput("post_rst.d3_x", 32'(d3_x), 1);
        checkOutput("post_rst.d3_pix_tick", 32'(d3_pt), 1);

        $display("[TB] enable hold with CLK_DIV=2");
        doReset();
        applyStimulus(13, 1'b1);
        checkOutput("hold.pre_x", 32'(d2_x), 6);
        applyStimulus(5, 1'b0);
        checkOutput("hold.x", 32'(d2_x), 6);
        checkOutput("hold.pix_tick", 32'(d2_pt), 0);
        checkOutput("hold.d1_line_start", 32'(d1_ls), 0);
        applyStimulus(1, 1'b1);
        checkOutput("resume.x", 32'(d2_x), 7);
        checkOutput("resume.pix_tick", 32'(d2_pt), 1);
        applyStimulus(1, 1'b1);
        checkOutput("resume2.x", 32'(d2_x), 7);
        checkOutput("resume2.pix_tick", 32'(d2_pt), 0);

        $display("[TB] active-high polarity with CLK_DIV=3");
        doReset();
        applyStimulus(30, 1'b1);
        checkOutput("pol.d3_x", 32'(d3_x), 10);
        checkOutput("pol.d3_hsync", 32'(d3_hs), 1);
        checkOutput("pol.d3_vsync", 32'(d3_vs), 0);
        applyStimulus(6, 1'b1);
        checkOutput("pol.d3_x12", 32'(d3_x), 12);
        checkOutput("pol.d3_hsync12", 32'(d3_hs), 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
        $display("[TB] frame counter over three frames");
        doReset();
        applyStimulus(3 * HT * VT, 1'b1);
        checkOutput("fc.three", 32'(d1_fc), 3);
        checkOutput("fc.odd", 32'(d1_odd), 1);
`endif

        $display("[TB] randomized enable and reset");
        doReset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
